// File: rtl/ebr_pkg.sv
// Shared types and defaults for the ebr_ram output drain stage.
package ebr_pkg;
    localparam int EBR_WORD_W             = 16;
    localparam int EBR_FIFO_DEPTH_DEFAULT = 8;
    localparam int EBR_FIFO_PTR_W         = $clog2(EBR_FIFO_DEPTH_DEFAULT) + 1;
    localparam int EBR_DROP_W_DEFAULT     = 16;

    typedef logic [EBR_WORD_W-1:0] ebr_word_t;
endpackage

// File: rtl/ebr_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// No reset on the array so it can map onto distributed RAM.
module ebr_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/ebr_out_fifo.sv
// Drain buffer for the ebr_ram valid-only stream: re-presents words on ready/valid
// and counts words lost to a full buffer instead of dropping them silently.
module ebr_out_fifo
    import ebr_pkg::*;
#(
    parameter int WIDTH  = EBR_WORD_W,
    parameter int DEPTH  = EBR_FIFO_DEPTH_DEFAULT,
    parameter int DROP_W = EBR_DROP_W_DEFAULT
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic [WIDTH-1:0]         i_in_data,
    input  logic                     i_in_valid,
    output logic [WIDTH-1:0]         o_out_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_overflow,
    output logic [DROP_W-1:0]        o_drop_count,
    input  logic                     i_clear_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]     PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_count;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic [WIDTH-1:0]  w_rd_data;

    // Extra pointer MSB separates the full and empty cases when the low bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_pop  = !w_empty && i_out_ready;
    assign w_push = i_in_valid && (!w_full || w_pop);
    assign w_drop = i_in_valid && w_full && !w_pop;

    ebr_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clock   (i_clock),
        .i_wr_en   (w_push && i_reset_n),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (i_in_data),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // A drop in the same cycle as a clear wins: the fresh loss must stay visible.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (i_clear_overflow) begin
                r_drop_count <= DROP_ONE;
            end else if (r_drop_count != DROP_MAX) begin
                r_drop_count <= r_drop_count + DROP_ONE;
            end
        end else if (i_clear_overflow) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign o_out_valid  = !w_empty;
    assign o_out_data   = w_empty ? '0 : w_rd_data;
    assign o_count      = r_wr_ptr - r_rd_ptr;
    assign o_full       = w_full;
    assign o_overflow   = r_overflow;
    assign o_drop_count = r_drop_count;
endmodule

// File: tb/tb_ebr_out_fifo.sv
// Directed bench for ebr_out_fifo with a queue-based reference model.
module tb_ebr_out_fifo;
    import ebr_pkg::*;

    localparam int DEPTH  = 8;
    localparam int DROP_W = 16;

    logic              clk;
    logic              i_reset_n;
    ebr_word_t         i_in_data;
    logic              i_in_valid;
    ebr_word_t         o_out_data;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [3:0]        o_count;
    logic              o_full;
    logic              o_overflow;
    logic [DROP_W-1:0] o_drop_count;
    logic              i_clear_overflow;

    ebr_out_fifo #(.WIDTH(16), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .i_clock          (clk),
        .i_reset_n        (i_reset_n),
        .i_in_data        (i_in_data),
        .i_in_valid       (i_in_valid),
        .o_out_data       (o_out_data),
        .o_out_valid      (o_out_valid),
        .i_out_ready      (i_out_ready),
        .o_count          (o_count),
        .o_full           (o_full),
        .o_overflow       (o_overflow),
        .o_drop_count     (o_drop_count),
        .i_clear_overflow (i_clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_total = 0;
    int        n_pass  = 0;
    ebr_word_t exp_q[$];
    int        m_drop  = 0;
    logic      m_ovf   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_status(input string tag);
        check({tag, ".count"}, 32'(o_count), 32'(exp_q.size()));
        check({tag, ".full"},  32'(o_full),  32'(exp_q.size() == DEPTH));
        check({tag, ".valid"}, 32'(o_out_valid), 32'(exp_q.size() != 0));
        check({tag, ".ovf"},   32'(o_overflow), 32'(m_ovf));
        check({tag, ".drops"}, 32'(o_drop_count), 32'(m_drop));
    endtask

    // One clock with the given inputs; head data is checked before the edge.
    task automatic step(input string tag, input logic v, input ebr_word_t d,
                        input logic rdy, input logic clr);
        logic pop;
        logic push;
        i_in_valid       = v;
        i_in_data        = d;
        i_out_ready      = rdy;
        i_clear_overflow = clr;
        #1;
        if (exp_q.size() != 0) check({tag, ".head"}, 32'(o_out_data), 32'(exp_q[0]));
        else                   check({tag, ".head0"}, 32'(o_out_data), 32'h0);
        pop  = (exp_q.size() != 0) && rdy;
        push = v && ((exp_q.size() < DEPTH) || pop);
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back(d);
        if (v && !push) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 1 : m_drop + 1;
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
        end
        @(posedge clk);
        #1;
        check_status(tag);
    endtask

    task automatic reset_cycle(input string tag);
        i_reset_n        = 1'b0;
        i_in_valid       = 1'b1;
        i_in_data        = 16'hAAAA;
        i_out_ready      = 1'b1;
        i_clear_overflow = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
        check_status(tag);
        check({tag, ".data"}, 32'(o_out_data), 32'h0);
        i_reset_n = 1'b1;
    endtask

    initial begin
        i_reset_n        = 1'b0;
        i_in_valid       = 1'b0;
        i_in_data        = '0;
        i_out_ready      = 1'b0;
        i_clear_overflow = 1'b0;
        #1;

        reset_cycle("rst_a");
        reset_cycle("rst_b");
        step("idle_post_rst", 1'b0, 16'h0, 1'b1, 1'b0);
        step("idle_post_rst2", 1'b0, 16'h0, 1'b0, 1'b0);

        // Streaming with ready high: each word leaves one cycle after its push.
        for (int k = 1; k <= 5; k++) begin
            step("stream", 1'b1, ebr_word_t'(k), 1'b1, 1'b0);
            check("stream.peak", 32'(o_count), 32'h1);
        end
        step("stream_tail", 1'b0, 16'h0, 1'b1, 1'b0);

        // Fill past capacity with ready low: three words dropped.
        for (int k = 0; k < 11; k++) begin
            step("fill", 1'b1, ebr_word_t'(16'h0100 + k), 1'b0, 1'b0);
        end
        check("fill.drops3", 32'(o_drop_count), 32'd3);
        check("fill.ovf", 32'(o_overflow), 32'd1);

        // Full with simultaneous push and pop: occupancy holds, order preserved.
        for (int k = 0; k < 4; k++) begin
            step("full_pp", 1'b1, ebr_word_t'(16'h0200 + k), 1'b1, 1'b0);
            check("full_pp.cnt8", 32'(o_count), 32'd8);
        end
        check("full_pp.nodrop", 32'(o_drop_count), 32'd3);

        // Clear coinciding with a drop, then a plain clear.
        step("clr_drop", 1'b1, 16'h0300, 1'b0, 1'b1);
        check("clr_drop.cnt1", 32'(o_drop_count), 32'd1);
        step("clr_only", 1'b0, 16'h0, 1'b0, 1'b1);
        check("clr_only.ovf0", 32'(o_overflow), 32'd0);

        // Hold with ready low: head must stay stable.
        step("hold", 1'b0, 16'h0, 1'b0, 1'b0);
        step("hold2", 1'b0, 16'h0, 1'b0, 1'b0);

        for (int k = 0; k < 3; k++) step("drain3", 1'b0, 16'h0, 1'b1, 1'b0);
        check("pre_rst.cnt5", 32'(o_count), 32'd5);

        reset_cycle("rst_mid");
        step("beef_push", 1'b1, 16'hBEEF, 1'b0, 1'b0);
        step("beef_pop", 1'b0, 16'h0, 1'b1, 1'b0);
        step("empty_end", 1'b0, 16'h0, 1'b1, 1'b0);

        // Wrap the pointers a few more times with mixed traffic.
        for (int k = 0; k < 20; k++) begin
            step("mix", (k % 3) != 2, ebr_word_t'(16'h0400 + k), (k % 2) == 0, 1'b0);
        end
        for (int k = 0; k < 10; k++) step("final_drain", 1'b0, 16'h0, 1'b1, 1'b0);
        check("final.empty", 32'(o_out_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
